// File: rtl/lnrv_exu_csr_rmw.sv
// Multi-cycle CSR read-modify-write unit (CSRRW/CSRRS/CSRRC, reg or zimm source); optional illegal check via LNRV_CSR_ILLEGAL_CHK_EN.
// Latency: accept -> read request +1 -> response +2 -> writebacks +3 -> ready +4; CSRRW rd=x0 skips the read (ready +2).
// Backpressure: one op in flight; read/writeback/exception valids are held until their own rdy, op_rdy only in IDLE.
module lnrv_exu_csr_rmw #(
    parameter int XLEN   = 32,
    parameter int GPR_AW = 5
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              op_vld,
    output logic              op_rdy,
    input  logic              op_rw,
    input  logic              op_rs,
    input  logic              op_rc,
    input  logic              op_imm,
    input  logic              src_is_x0,
    input  logic [4:0]        zimm,
    input  logic [XLEN-1:0]   rs1_rdata,
    input  logic [GPR_AW-1:0] rd_idx,
    input  logic [11:0]       csr_idx,
    input  logic [1:0]        priv_lvl,

    output logic              csr_rd_vld,
    input  logic              csr_rd_rdy,
    output logic [11:0]       csr_rd_idx,
    input  logic              csr_rsp_vld,
    input  logic [XLEN-1:0]   csr_rsp_data,

    output logic              gpr_wbck_vld,
    input  logic              gpr_wbck_rdy,
    output logic [GPR_AW-1:0] gpr_wbck_idx,
    output logic [XLEN-1:0]   gpr_wbck_wdata,

    output logic              csr_wbck_vld,
    input  logic              csr_wbck_rdy,
    output logic [11:0]       csr_wbck_idx,
    output logic [XLEN-1:0]   csr_wbck_wdata,

    output logic              excp_vld,
    input  logic              excp_rdy,
    output logic [XLEN-1:0]   excp_tval
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RREQ = 3'd1,
        S_RRSP = 3'd2,
        S_WBCK = 3'd3,
        S_EXCP = 3'd4
    } state_t;

    state_t state, state_nxt;

    logic              op_rw_q, op_rs_q, op_rc_q;
    logic [XLEN-1:0]   src_q;
    logic [XLEN-1:0]   old_q;
    logic [GPR_AW-1:0] rd_idx_q;
    logic [11:0]       csr_idx_q;
    logic              do_gpr_q, do_csr_q;
    logic              gpr_done_q, csr_done_q;

    logic              op_hs;
    logic [XLEN-1:0]   src_in;
    logic              do_csr_in, do_read_in;
    logic              illegal;
    logic              gpr_ok, csr_ok;
    logic [XLEN-1:0]   new_val;

    assign op_hs      = op_vld & op_rdy;
    assign src_in     = op_imm ? {{(XLEN-5){1'b0}}, zimm} : rs1_rdata;
    assign do_csr_in  = op_rw | ~src_is_x0;
    // CSRRW to x0 must not read the CSR at all (read side effects).
    assign do_read_in = ~(op_rw & (rd_idx == '0));

`ifdef LNRV_CSR_ILLEGAL_CHK_EN
    assign illegal = (csr_idx[9:8] > priv_lvl) | ((csr_idx[11:10] == 2'b11) & do_csr_in);
`else
    logic unused_cfg;
    assign illegal    = 1'b0;
    assign unused_cfg = ^{priv_lvl, excp_rdy};
`endif

    always_comb begin
        new_val = old_q;
        if (op_rw_q)      new_val = src_q;
        else if (op_rs_q) new_val = old_q | src_q;
        else if (op_rc_q) new_val = old_q & ~src_q;
    end

    // A channel is satisfied if not needed, already done, or handshaking now.
    assign gpr_ok = ~do_gpr_q | gpr_done_q | gpr_wbck_rdy;
    assign csr_ok = ~do_csr_q | csr_done_q | csr_wbck_rdy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (op_hs) begin
                    if (illegal)         state_nxt = S_EXCP;
                    else if (do_read_in) state_nxt = S_RREQ;
                    else                 state_nxt = S_WBCK;
                end
            end
            S_RREQ: if (csr_rd_rdy)      state_nxt = S_RRSP;
            S_RRSP: if (csr_rsp_vld)     state_nxt = S_WBCK;
            S_WBCK: if (gpr_ok && csr_ok) state_nxt = S_IDLE;
`ifdef LNRV_CSR_ILLEGAL_CHK_EN
            S_EXCP: if (excp_rdy)        state_nxt = S_IDLE;
`else
            S_EXCP:                      state_nxt = S_IDLE;
`endif
            default:                     state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        op_rdy       = 1'b0;
        csr_rd_vld   = 1'b0;
        gpr_wbck_vld = 1'b0;
        csr_wbck_vld = 1'b0;
        excp_vld     = 1'b0;
        case (state)
            S_IDLE: op_rdy     = 1'b1;
            S_RREQ: csr_rd_vld = 1'b1;
            S_WBCK: begin
                gpr_wbck_vld = do_gpr_q & ~gpr_done_q;
                csr_wbck_vld = do_csr_q & ~csr_done_q;
            end
`ifdef LNRV_CSR_ILLEGAL_CHK_EN
            S_EXCP: excp_vld   = 1'b1;
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_rw_q    <= 1'b0;
            op_rs_q    <= 1'b0;
            op_rc_q    <= 1'b0;
            src_q      <= '0;
            old_q      <= '0;
            rd_idx_q   <= '0;
            csr_idx_q  <= '0;
            do_gpr_q   <= 1'b0;
            do_csr_q   <= 1'b0;
            gpr_done_q <= 1'b0;
            csr_done_q <= 1'b0;
        end else begin
            if (op_hs) begin
                op_rw_q    <= op_rw;
                op_rs_q    <= op_rs;
                op_rc_q    <= op_rc;
                src_q      <= src_in;
                old_q      <= '0;
                rd_idx_q   <= rd_idx;
                csr_idx_q  <= csr_idx;
                do_gpr_q   <= (rd_idx != '0);
                do_csr_q   <= do_csr_in;
                gpr_done_q <= 1'b0;
                csr_done_q <= 1'b0;
            end
            if (state == S_RRSP && csr_rsp_vld) old_q <= csr_rsp_data;
            if (gpr_wbck_vld && gpr_wbck_rdy)   gpr_done_q <= 1'b1;
            if (csr_wbck_vld && csr_wbck_rdy)   csr_done_q <= 1'b1;
        end
    end

    assign csr_rd_idx     = csr_idx_q;
    assign gpr_wbck_idx   = rd_idx_q;
    assign gpr_wbck_wdata = old_q;
    assign csr_wbck_idx   = csr_idx_q;
    assign csr_wbck_wdata = new_val;

`ifdef LNRV_CSR_ILLEGAL_CHK_EN
    assign excp_tval = {{(XLEN-12){1'b0}}, csr_idx_q};
`else
    assign excp_tval = '0;
`endif

endmodule

// File: tb/tb_lnrv_exu_csr_rmw.sv
// Bench for lnrv_exu_csr_rmw: scoreboard of expected GPR/CSR/exception writebacks per scenario.
module tb_lnrv_exu_csr_rmw;
    localparam int XLEN = 32;
    localparam int AW   = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst_n;
    logic            op_vld, op_rdy, op_rw, op_rs, op_rc, op_imm, src_is_x0;
    logic [4:0]      zimm;
    logic [XLEN-1:0] rs1_rdata;
    logic [AW-1:0]   rd_idx;
    logic [11:0]     csr_idx;
    logic [1:0]      priv_lvl;
    logic            csr_rd_vld, csr_rd_rdy;
    logic [11:0]     csr_rd_idx;
    logic            csr_rsp_vld;
    logic [XLEN-1:0] csr_rsp_data;
    logic            gpr_wbck_vld, gpr_wbck_rdy;
    logic [AW-1:0]   gpr_wbck_idx;
    logic [XLEN-1:0] gpr_wbck_wdata;
    logic            csr_wbck_vld, csr_wbck_rdy;
    logic [11:0]     csr_wbck_idx;
    logic [XLEN-1:0] csr_wbck_wdata;
    logic            excp_vld, excp_rdy;
    logic [XLEN-1:0] excp_tval;

    lnrv_exu_csr_rmw #(.XLEN(XLEN), .GPR_AW(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .op_vld(op_vld), .op_rdy(op_rdy), .op_rw(op_rw), .op_rs(op_rs), .op_rc(op_rc),
        .op_imm(op_imm), .src_is_x0(src_is_x0), .zimm(zimm), .rs1_rdata(rs1_rdata),
        .rd_idx(rd_idx), .csr_idx(csr_idx), .priv_lvl(priv_lvl),
        .csr_rd_vld(csr_rd_vld), .csr_rd_rdy(csr_rd_rdy), .csr_rd_idx(csr_rd_idx),
        .csr_rsp_vld(csr_rsp_vld), .csr_rsp_data(csr_rsp_data),
        .gpr_wbck_vld(gpr_wbck_vld), .gpr_wbck_rdy(gpr_wbck_rdy),
        .gpr_wbck_idx(gpr_wbck_idx), .gpr_wbck_wdata(gpr_wbck_wdata),
        .csr_wbck_vld(csr_wbck_vld), .csr_wbck_rdy(csr_wbck_rdy),
        .csr_wbck_idx(csr_wbck_idx), .csr_wbck_wdata(csr_wbck_wdata),
        .excp_vld(excp_vld), .excp_rdy(excp_rdy), .excp_tval(excp_tval)
    );

    typedef struct packed {
        logic [11:0]     idx;
        logic [XLEN-1:0] dat;
    } wb_t;

    int tests = 0;
    int fails = 0;

    // expected results, pushed by the tests as stimulus is driven
    wb_t exp_gpr[$];
    wb_t exp_csr[$];
    wb_t exp_exc[$];
    int  chk_gpr = 0, chk_csr = 0, chk_exc = 0;

    // observed events, written only by the monitor
    wb_t obs_gpr[64];
    wb_t obs_csr[64];
    wb_t obs_exc[64];
    int  n_gpr = 0, n_csr = 0, n_exc = 0, n_rd = 0;
    int  n_gpr_vcyc = 0, n_csr_vcyc = 0, n_hold_err = 0;
    logic            pg_v = 1'b0, pc_v = 1'b0;
    logic [11:0]     pg_i, pc_i;
    logic [XLEN-1:0] pg_d, pc_d;

    always @(negedge clk) begin
        if (rst_n) begin
            if (csr_rd_vld && csr_rd_rdy) n_rd++;
            if (gpr_wbck_vld) begin
                n_gpr_vcyc++;
                if (pg_v && ({7'd0, gpr_wbck_idx} != pg_i || gpr_wbck_wdata != pg_d)) n_hold_err++;
            end
            if (csr_wbck_vld) begin
                n_csr_vcyc++;
                if (pc_v && (csr_wbck_idx != pc_i || csr_wbck_wdata != pc_d)) n_hold_err++;
            end
            if (gpr_wbck_vld && gpr_wbck_rdy) begin
                obs_gpr[n_gpr & 63] = '{idx: {7'd0, gpr_wbck_idx}, dat: gpr_wbck_wdata};
                n_gpr++;
            end
            if (csr_wbck_vld && csr_wbck_rdy) begin
                obs_csr[n_csr & 63] = '{idx: csr_wbck_idx, dat: csr_wbck_wdata};
                n_csr++;
            end
            if (excp_vld && excp_rdy) begin
                obs_exc[n_exc & 63] = '{idx: 12'd0, dat: excp_tval};
                n_exc++;
            end
            pg_v = gpr_wbck_vld && !gpr_wbck_rdy;
            pg_i = {7'd0, gpr_wbck_idx};
            pg_d = gpr_wbck_wdata;
            pc_v = csr_wbck_vld && !csr_wbck_rdy;
            pc_i = csr_wbck_idx;
            pc_d = csr_wbck_wdata;
        end else begin
            pg_v = 1'b0;
            pc_v = 1'b0;
        end
    end

    // CSR file model: answers each read one cycle after the request with csr_val
    logic [XLEN-1:0] csr_val = '0;
    logic            auto_rsp = 1'b1;
    logic            rsp_hit;
    logic            auto_vld = 1'b0, inj_vld = 1'b0;
    logic [XLEN-1:0] auto_dat = '0, inj_dat = '0;
    assign csr_rsp_vld  = auto_vld | inj_vld;
    assign csr_rsp_data = inj_vld ? inj_dat : auto_dat;

    always @(posedge clk) begin
        rsp_hit = rst_n && csr_rd_vld && csr_rd_rdy && auto_rsp;
        #1;
        auto_vld = rsp_hit;
        auto_dat = rsp_hit ? csr_val : '0;
    end

    task automatic issue(input logic rw, rs, rc, imm, x0, input logic [4:0] zi,
                         input logic [XLEN-1:0] rs1, input logic [4:0] rd,
                         input logic [11:0] idx, input logic [1:0] pl, output int lat);
        int n;
        @(posedge clk); #1;
        op_vld = 1'b1; op_rw = rw; op_rs = rs; op_rc = rc; op_imm = imm;
        src_is_x0 = x0; zimm = zi; rs1_rdata = rs1; rd_idx = rd; csr_idx = idx; priv_lvl = pl;
        n = 0;
        do begin @(negedge clk); n++; end while (!op_rdy && n < 50);
        @(posedge clk); #1;
        op_vld = 1'b0;
        rs1_rdata = '1;
        lat = 0;
        while (lat < 100) begin
            @(negedge clk);
            lat++;
            if (op_rdy) break;
        end
        tests++;
        if (!op_rdy) begin
            fails++;
            $display("FAIL op_complete idx=%03h: op_rdy=%b after %0d cycles, required 1", idx, op_rdy, lat);
        end
    endtask

    task automatic sb_check(input string name);
        wb_t e;
        while (exp_gpr.size() > 0) begin
            e = exp_gpr.pop_front();
            tests++;
            if (chk_gpr >= n_gpr) begin
                fails++;
                $display("FAIL %s gpr_missing: got none, required idx=%0d data=%08h", name, e.idx, e.dat);
            end else begin
                if (obs_gpr[chk_gpr & 63] !== e) begin
                    fails++;
                    $display("FAIL %s gpr_wbck: got idx=%0d data=%08h, required idx=%0d data=%08h",
                             name, obs_gpr[chk_gpr & 63].idx, obs_gpr[chk_gpr & 63].dat, e.idx, e.dat);
                end
                chk_gpr++;
            end
        end
        while (exp_csr.size() > 0) begin
            e = exp_csr.pop_front();
            tests++;
            if (chk_csr >= n_csr) begin
                fails++;
                $display("FAIL %s csr_missing: got none, required idx=%03h data=%08h", name, e.idx, e.dat);
            end else begin
                if (obs_csr[chk_csr & 63] !== e) begin
                    fails++;
                    $display("FAIL %s csr_wbck: got idx=%03h data=%08h, required idx=%03h data=%08h",
                             name, obs_csr[chk_csr & 63].idx, obs_csr[chk_csr & 63].dat, e.idx, e.dat);
                end
                chk_csr++;
            end
        end
        while (exp_exc.size() > 0) begin
            e = exp_exc.pop_front();
            tests++;
            if (chk_exc >= n_exc) begin
                fails++;
                $display("FAIL %s excp_missing: got none, required tval=%08h", name, e.dat);
            end else begin
                if (obs_exc[chk_exc & 63].dat !== e.dat) begin
                    fails++;
                    $display("FAIL %s excp_tval: got %08h, required %08h", name, obs_exc[chk_exc & 63].dat, e.dat);
                end
                chk_exc++;
            end
        end
        tests++;
        if (chk_gpr != n_gpr || chk_csr != n_csr || chk_exc != n_exc) begin
            fails++;
            $display("FAIL %s extra_events: got gpr=%0d csr=%0d excp=%0d, required gpr=%0d csr=%0d excp=%0d",
                     name, n_gpr, n_csr, n_exc, chk_gpr, chk_csr, chk_exc);
            chk_gpr = n_gpr; chk_csr = n_csr; chk_exc = n_exc;
        end
    endtask

    task automatic test_reset;
        #1;
        tests++;
        if (op_rdy !== 1'b1 || csr_rd_vld !== 1'b0 || gpr_wbck_vld !== 1'b0 ||
            csr_wbck_vld !== 1'b0 || excp_vld !== 1'b0) begin
            fails++;
            $display("FAIL reset_ctrl: got rdy=%b rd=%b gv=%b cv=%b ev=%b, required 1 0 0 0 0",
                     op_rdy, csr_rd_vld, gpr_wbck_vld, csr_wbck_vld, excp_vld);
        end
        tests++;
        if (csr_rd_idx !== 12'd0 || gpr_wbck_idx !== '0 || gpr_wbck_wdata !== '0 ||
            csr_wbck_idx !== 12'd0 || csr_wbck_wdata !== '0 || excp_tval !== '0) begin
            fails++;
            $display("FAIL reset_data: got %03h %0d %08h %03h %08h %08h, required all zero",
                     csr_rd_idx, gpr_wbck_idx, gpr_wbck_wdata, csr_wbck_idx, csr_wbck_wdata, excp_tval);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_csrrs;
        int lat, rd0;
        rd0 = n_rd;
        csr_val = 32'h0000_000F;
        exp_gpr.push_back('{idx: 12'd5, dat: 32'h0000_000F});
        exp_csr.push_back('{idx: 12'h340, dat: 32'h0000_00FF});
        issue(0, 1, 0, 0, 0, 5'd0, 32'h0000_00F0, 5'd5, 12'h340, 2'd3, lat);
        tests++;
        if (lat !== 4) begin fails++; $display("FAIL csrrs_latency: got %0d, required 4", lat); end
        tests++;
        if (n_rd - rd0 !== 1) begin fails++; $display("FAIL csrrs_reads: got %0d, required 1", n_rd - rd0); end
        sb_check("csrrs");
    endtask

    task automatic test_csrrc_imm;
        int lat;
        csr_val = 32'hFFFF_FFFF;
        exp_gpr.push_back('{idx: 12'd7, dat: 32'hFFFF_FFFF});
        exp_csr.push_back('{idx: 12'h341, dat: 32'hFFFF_FFFC});
        issue(0, 0, 1, 1, 0, 5'd3, 32'h0000_0000, 5'd7, 12'h341, 2'd3, lat);
        sb_check("csrrci");
    endtask

    task automatic test_no_csr_write;
        int lat, cv0, rd0;
        cv0 = n_csr_vcyc;
        rd0 = n_rd;
        csr_val = 32'hABCD_0123;
        exp_gpr.push_back('{idx: 12'd9, dat: 32'hABCD_0123});
        issue(0, 1, 0, 0, 1, 5'd0, 32'h0000_DEAD, 5'd9, 12'h342, 2'd3, lat);
        tests++;
        if (n_csr_vcyc != cv0) begin fails++; $display("FAIL rs_x0_csr_vld: got %0d cycles, required 0", n_csr_vcyc - cv0); end
        tests++;
        if (n_rd - rd0 !== 1) begin fails++; $display("FAIL rs_x0_reads: got %0d, required 1", n_rd - rd0); end
        sb_check("csrrs_x0");
        // rd=x0 and no write: read still happens, WBCK lasts one cycle
        rd0 = n_rd;
        issue(0, 0, 1, 1, 1, 5'd0, 32'h0, 5'd0, 12'h343, 2'd3, lat);
        tests++;
        if (lat !== 4 || n_rd - rd0 !== 1) begin
            fails++;
            $display("FAIL rc_nowb: got latency=%0d reads=%0d, required 4 and 1", lat, n_rd - rd0);
        end
        sb_check("csrrc_nowb");
    endtask

    task automatic test_csrrw;
        int lat, rd0;
        rd0 = n_rd;
        exp_csr.push_back('{idx: 12'h343, dat: 32'h1234_5678});
        issue(1, 0, 0, 0, 0, 5'd0, 32'h1234_5678, 5'd0, 12'h343, 2'd3, lat);
        tests++;
        if (lat !== 2) begin fails++; $display("FAIL rw_x0_latency: got %0d, required 2", lat); end
        tests++;
        if (n_rd != rd0) begin fails++; $display("FAIL rw_x0_reads: got %0d, required 0", n_rd - rd0); end
        sb_check("csrrw_x0");
        csr_val = 32'h0000_0A0A;
        exp_gpr.push_back('{idx: 12'd31, dat: 32'h0000_0A0A});
        exp_csr.push_back('{idx: 12'h344, dat: 32'hCAFE_F00D});
        issue(1, 0, 0, 0, 1, 5'd0, 32'hCAFE_F00D, 5'd31, 12'h344, 2'd3, lat);
        sb_check("csrrw");
    endtask

    task automatic test_backpressure;
        int lat, gv0, hold0, cs0;
        bit seen;
        gv0 = n_gpr_vcyc;
        hold0 = n_hold_err;
        cs0 = n_csr;
        csr_val = 32'h8000_0001;
        gpr_wbck_rdy = 1'b0;
        exp_gpr.push_back('{idx: 12'd12, dat: 32'h8000_0001});
        exp_csr.push_back('{idx: 12'h345, dat: 32'h8000_0000});
        fork
            issue(0, 0, 1, 0, 0, 5'd0, 32'h0000_0001, 5'd12, 12'h345, 2'd3, lat);
            begin
                seen = 0;
                for (int i = 0; i < 20 && !seen; i++) begin
                    @(negedge clk);
                    if (gpr_wbck_vld) seen = 1;
                end
                repeat (3) @(posedge clk);
                #1 gpr_wbck_rdy = 1'b1;
            end
        join
        gpr_wbck_rdy = 1'b1;
        tests++;
        if (n_gpr_vcyc - gv0 !== 4) begin fails++; $display("FAIL bp_gpr_vld_cycles: got %0d, required 4", n_gpr_vcyc - gv0); end
        tests++;
        if (n_csr - cs0 !== 1) begin fails++; $display("FAIL bp_csr_writes: got %0d, required 1", n_csr - cs0); end
        tests++;
        if (n_hold_err != hold0) begin fails++; $display("FAIL bp_hold_stable: got %0d changes, required 0", n_hold_err - hold0); end
        tests++;
        if (lat !== 7) begin fails++; $display("FAIL bp_latency: got %0d, required 7", lat); end
        sb_check("backpressure");
    endtask

    task automatic test_illegal;
        int lat, rd0;
        rd0 = n_rd;
        csr_val = 32'h0000_0005;
`ifdef LNRV_CSR_ILLEGAL_CHK_EN
        exp_exc.push_back('{idx: 12'd0, dat: 32'h0000_0300});
`else
        exp_gpr.push_back('{idx: 12'd2, dat: 32'h0000_0005});
        exp_csr.push_back('{idx: 12'h300, dat: 32'h0000_0005});
`endif
        issue(0, 1, 0, 0, 0, 5'd0, 32'h0000_0001, 5'd2, 12'h300, 2'd0, lat);
        tests++;
`ifdef LNRV_CSR_ILLEGAL_CHK_EN
        if (n_rd != rd0) begin fails++; $display("FAIL illegal_priv_reads: got %0d, required 0", n_rd - rd0); end
`else
        if (n_rd - rd0 !== 1) begin fails++; $display("FAIL illegal_priv_reads: got %0d, required 1", n_rd - rd0); end
`endif
        sb_check("illegal_priv");
        csr_val = 32'h0000_0077;
`ifdef LNRV_CSR_ILLEGAL_CHK_EN
        exp_exc.push_back('{idx: 12'd0, dat: 32'h0000_0C00});
`else
        exp_gpr.push_back('{idx: 12'd4, dat: 32'h0000_0077});
        exp_csr.push_back('{idx: 12'hC00, dat: 32'h0000_00AA});
`endif
        issue(1, 0, 0, 0, 0, 5'd0, 32'h0000_00AA, 5'd4, 12'hC00, 2'd3, lat);
        sb_check("illegal_ro");
        // pure read of a read-only CSR is legal either way
        csr_val = 32'h0001_2345;
        exp_gpr.push_back('{idx: 12'd6, dat: 32'h0001_2345});
        issue(0, 1, 0, 0, 1, 5'd0, 32'h0, 5'd6, 12'hC00, 2'd3, lat);
        sb_check("ro_read");
    endtask

    task automatic test_reset_mid_op;
        int lat, g0, c0;
        g0 = n_gpr;
        c0 = n_csr;
        auto_rsp = 1'b0;
        @(posedge clk); #1;
        op_vld = 1'b1; op_rw = 0; op_rs = 1; op_rc = 0; op_imm = 0; src_is_x0 = 0;
        rs1_rdata = 32'h0000_000F; rd_idx = 5'd3; csr_idx = 12'h346; priv_lvl = 2'd3;
        @(posedge clk); #1;
        op_vld = 1'b0;
        @(posedge clk); #1;
        tests++;
        if (op_rdy !== 1'b0 || csr_rd_vld !== 1'b0) begin
            fails++;
            $display("FAIL rrsp_wait: got rdy=%b rd_vld=%b, required 0 0", op_rdy, csr_rd_vld);
        end
        #2 rst_n = 1'b0;
        #1;
        tests++;
        if (op_rdy !== 1'b1 || csr_rd_vld !== 1'b0 || gpr_wbck_vld !== 1'b0 || csr_wbck_vld !== 1'b0) begin
            fails++;
            $display("FAIL async_reset: got rdy=%b rd=%b gv=%b cv=%b, required 1 0 0 0",
                     op_rdy, csr_rd_vld, gpr_wbck_vld, csr_wbck_vld);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        inj_vld = 1'b1; inj_dat = 32'h0000_0055;
        @(posedge clk); #1;
        inj_vld = 1'b0;
        repeat (3) @(negedge clk);
        tests++;
        if (n_gpr != g0 || n_csr != c0 || op_rdy !== 1'b1) begin
            fails++;
            $display("FAIL late_rsp_ignored: got gpr=%0d csr=%0d rdy=%b, required 0 0 1", n_gpr - g0, n_csr - c0, op_rdy);
        end
        auto_rsp = 1'b1;
        csr_val = 32'h0000_0001;
        exp_gpr.push_back('{idx: 12'd3, dat: 32'h0000_0001});
        exp_csr.push_back('{idx: 12'h346, dat: 32'h0000_0101});
        issue(0, 1, 0, 0, 0, 5'd0, 32'h0000_0100, 5'd3, 12'h346, 2'd3, lat);
        tests++;
        if (lat !== 4) begin fails++; $display("FAIL post_reset_latency: got %0d, required 4", lat); end
        sb_check("post_reset");
    endtask

    initial begin
        rst_n = 1'b0;
        op_vld = 0; op_rw = 0; op_rs = 0; op_rc = 0; op_imm = 0; src_is_x0 = 0;
        zimm = '0; rs1_rdata = '0; rd_idx = '0; csr_idx = '0; priv_lvl = '0;
        csr_rd_rdy = 1'b1; gpr_wbck_rdy = 1'b1; csr_wbck_rdy = 1'b1; excp_rdy = 1'b1;
        test_reset();
        test_csrrs();
        test_csrrc_imm();
        test_no_csr_write();
        test_csrrw();
        test_backpressure();
        test_illegal();
        test_reset_mid_op();
        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/lnrv_exu_csr_rmw.md
# lnrv_exu_csr_rmw

Multi-cycle CSR read-modify-write execution unit for the EXU, parametrised in data width. It accepts one CSRRW/CSRRS/CSRRC (register or zimm) operation, reads the CSR over a request/response channel, computes the new value with internal bitwise logic (no ALU dependency), and drives independent GPR and CSR writeback handshakes. It applies the ISA write/read suppression rules and has optional privilege/read-only checking, compiled in by macro.

## Interface
- XLEN, 32, data width of CSR and GPR values
- GPR_AW, 5, GPR index width
- clk  in  1  clock
- rst_n  in  1  reset; one clock, reset asynchronous and active-low
- op_vld / op_rdy  in / out  1 / 1  operation handshake
- op_rw, op_rs, op_rc  in  1 each  one-hot operation select
- op_imm  in  1  source is zimm, not rs1
- src_is_x0  in  1  rs1 index (or zimm) is zero
- zimm  in  5  immediate source, zero-extended to XLEN
- rs1_rdata  in  XLEN  register source
- rd_idx  in  GPR_AW  destination GPR index
- csr_idx  in  12  CSR address
- priv_lvl  in  2  current privilege level
- csr_rd_vld / csr_rd_rdy  out / in  1 / 1  CSR read request handshake; csr_rd_idx out 12
- csr_rsp_vld  in  1; csr_rsp_data  in  XLEN  read response (always accepted)
- gpr_wbck_vld / gpr_wbck_rdy  out / in; gpr_wbck_idx out GPR_AW; gpr_wbck_wdata out XLEN
- csr_wbck_vld / csr_wbck_rdy  out / in; csr_wbck_idx out 12; csr_wbck_wdata out XLEN
- excp_vld / excp_rdy  out / in  illegal-instruction report; excp_tval out XLEN

## Operation
- FSM states: IDLE, RREQ, RRSP, WBCK, EXCP. Reset state IDLE.
- IDLE: op_rdy=1. On op handshake, capture all op fields, src = op_imm ? {0,zimm} : rs1_rdata.
- Flags at capture: do_gpr = (rd_idx!=0); do_csr = op_rw | ~src_is_x0; do_read = ~(op_rw & rd_idx==0).
- IDLE -> EXCP if illegal (Configuration); else -> RREQ if do_read; else -> WBCK with old=0.
- RREQ: csr_rd_vld=1, csr_rd_idx=captured index; on handshake -> RRSP.
- RRSP: wait csr_rsp_vld; latch old=csr_rsp_data -> WBCK. Response in any other state is ignored.
- New value: RW: src; RS: old|src; RC: old&~src.
- WBCK: gpr_wbck_vld=do_gpr & ~gpr_done, wdata=old; csr_wbck_vld=do_csr & ~csr_done, wdata=new. Each channel sets its done flag on its own handshake and drops vld next cycle. Exit to IDLE the cycle all required channels are done (same-cycle handshakes allowed). If neither required, WBCK lasts one cycle.
- EXCP: excp_vld=1, excp_tval={0,csr_idx}; on handshake -> IDLE. No read, no writebacks.
- op_rdy=0 in all states except IDLE; no back-to-back overlap.

## Timing
- Reset values: op_rdy=1, all *_vld=0, all idx/wdata/tval=0.
- Minimum latency (all rdy=1, response one cycle after request): op accept cycle 0, csr_rd_vld cycle 1, rsp cycle 2, writebacks cycle 3, op_rdy cycle 4.
- CSRRW rd=x0: writeback cycle 1, op_rdy cycle 2.
- All valid/data outputs are registered or decoded from state + captured registers only; no combinational path from any *_rdy to any *_vld.
- Valid held stable with data unchanged until handshake.
- rst_n assertion mid-operation: immediate return to IDLE, all valids drop asynchronously; outstanding response dropped.

## Configuration
- LNRV_CSR_ILLEGAL_CHK_EN defined: illegal = (csr_idx[9:8] > priv_lvl) | (csr_idx[11:10]==2'b11 & do_csr); illegal ops go to EXCP.
- Undefined: no check, EXCP unreachable, excp_vld tied 0, excp_tval tied 0; priv_lvl unused.

## Test plan
- CSRRS, rs1_rdata=0x0000_00F0, CSR reads 0x0000_000F, rd=5 -> gpr 5 <= 0x0F, CSR <= 0xFF, op_rdy again cycle 4.
- CSRRC zimm=0x3, CSR 0xFFFF_FFFF -> CSR <= 0xFFFF_FFFC; CSRRS with src_is_x0=1 -> read + gpr write only, csr_wbck_vld never asserts.
- CSRRW rd=0, rs1_rdata=0x1234_5678 -> no csr_rd_vld, no gpr write, CSR <= 0x1234_5678.
- Writeback backpressure: gpr_wbck_rdy low 3 cycles, csr_wbck_rdy high -> CSR write once, gpr vld/data held 3 cycles, exit after gpr handshake.
- With macro: priv_lvl=0, csr_idx=0x300 -> excp_vld, tval=0x300, no read/writeback; CSRRW to 0xC00 at priv 3 -> exception; without macro both complete normally.
- rst_n low while in RRSP, late response arrives in IDLE -> ignored, no writeback, next op executes correctly.
